// File: rtl/mem_arb_pkg.sv
// Shared encodings for the two-master memory arbiter: FSM states,
// master indices and access-width codes.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } state_t;

    localparam logic M0 = 1'b0;
    localparam logic M1 = 1'b1;

    localparam logic [1:0] WIDTH_BYTE = 2'd0;
    localparam logic [1:0] WIDTH_HALF = 2'd1;
    localparam logic [1:0] WIDTH_WORD = 2'd2;

endpackage

// File: rtl/arb_pick.sv
// Combinational winner selection: a held lock beats round-robin, and
// round-robin favours the master that did not own the last access.
module arb_pick
    import mem_arb_pkg::*;
(
    input  logic [1:0] reqs,
    input  logic       last_owner,
    input  logic       lock_hold,
    input  logic       lock_owner,
    output logic       winner
);

    always_comb begin
        winner = M0;
        if (lock_hold && reqs[lock_owner]) begin
            winner = lock_owner;
        end else if (reqs[M0] && reqs[M1]) begin
            winner = ~last_owner;
        end else if (reqs[M1]) begin
            winner = M1;
        end else begin
            winner = M0;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Two-master arbiter in front of a single memory slave: one access at a
// time, round-robin with lock retention, and a BUSY timeout that answers with err.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        m0_req,
    input  logic [31:0] m0_addr,
    input  logic [31:0] m0_wdata,
    input  logic        m0_we,
    input  logic [1:0]  m0_width,
    input  logic        m0_lock,
    output logic        m0_ack,
    output logic        m0_err,
    output logic [31:0] m0_rdata,
    input  logic        m1_req,
    input  logic [31:0] m1_addr,
    input  logic [31:0] m1_wdata,
    input  logic        m1_we,
    input  logic [1:0]  m1_width,
    input  logic        m1_lock,
    output logic        m1_ack,
    output logic        m1_err,
    output logic [31:0] m1_rdata,
    output logic        mem_req,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_dout,
    output logic        mem_write_en,
    output logic        mem_read_en,
    output logic [1:0]  mem_width,
    input  logic [31:0] mem_din,
    input  logic        mem_ack
);

    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    state_t state;
    state_t state_next;

    logic             owner;
    logic             last_owner;
    logic             lock_hold;
    logic             err_reg;
    logic [31:0]      rdata_reg;
    logic [31:0]      addr_reg;
    logic [31:0]      wdata_reg;
    logic             we_reg;
    logic [1:0]       width_reg;
    logic [CNT_W-1:0] count;
    logic [1:0]       reqs;
    logic             winner;
    logic             timeout;

    assign reqs    = {m1_req, m0_req};
    assign timeout = (count == CNT_W'(TIMEOUT_CYCLES - 1));

    arb_pick u_pick (
        .reqs       (reqs),
        .last_owner (last_owner),
        .lock_hold  (lock_hold),
        .lock_owner (last_owner),
        .winner     (winner)
    );

    // The held master is always the previous owner, so last_owner doubles as lock owner.
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            owner      <= M0;
            last_owner <= M1;
            lock_hold  <= 1'b0;
            err_reg    <= 1'b0;
            rdata_reg  <= '0;
            addr_reg   <= '0;
            wdata_reg  <= '0;
            we_reg     <= 1'b0;
            width_reg  <= '0;
            count      <= '0;
        end else begin
            state <= state_next;
            case (state)
                IDLE: begin
                    if (|reqs) begin
                        owner     <= winner;
                        addr_reg  <= (winner == M1) ? m1_addr  : m0_addr;
                        wdata_reg <= (winner == M1) ? m1_wdata : m0_wdata;
                        we_reg    <= (winner == M1) ? m1_we    : m0_we;
                        width_reg <= (winner == M1) ? m1_width : m0_width;
                        count     <= '0;
                    end
                    if (lock_hold && !reqs[last_owner]) begin
                        lock_hold <= 1'b0;
                    end
                end
                BUSY: begin
                    if (mem_ack) begin
                        rdata_reg <= mem_din;
                        err_reg   <= 1'b0;
                    end else if (timeout) begin
                        rdata_reg <= '0;
                        err_reg   <= 1'b1;
                    end else begin
                        count <= count + 1'b1;
                    end
                end
                RESP: begin
                    last_owner <= owner;
                    lock_hold  <= (owner == M1) ? m1_lock : m0_lock;
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        state_next   = state;
        mem_req      = 1'b0;
        mem_addr     = '0;
        mem_dout     = '0;
        mem_write_en = 1'b0;
        mem_read_en  = 1'b0;
        mem_width    = '0;
        m0_ack       = 1'b0;
        m0_err       = 1'b0;
        m0_rdata     = '0;
        m1_ack       = 1'b0;
        m1_err       = 1'b0;
        m1_rdata     = '0;
        case (state)
            IDLE: begin
                if (|reqs) begin
                    state_next = BUSY;
                end
            end
            BUSY: begin
                mem_req      = 1'b1;
                mem_addr     = addr_reg;
                mem_dout     = wdata_reg;
                mem_write_en = we_reg;
                mem_read_en  = ~we_reg;
                mem_width    = width_reg;
                if (mem_ack || timeout) begin
                    state_next = RESP;
                end
            end
            RESP: begin
                state_next = IDLE;
                if (owner == M1) begin
                    m1_ack   = 1'b1;
                    m1_err   = err_reg;
                    m1_rdata = rdata_reg;
                end else begin
                    m0_ack   = 1'b1;
                    m0_err   = err_reg;
                    m0_rdata = rdata_reg;
                end
            end
            default: state_next = IDLE;
        endcase
    end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 The block SHALL have parameter TIMEOUT_CYCLES, default 255, meaning the maximum BUSY cycles to wait for mem_ack before an error response.
REQ-002 The block SHALL have port clk  input  1  clock; all state changes on the rising edge.
REQ-003 The block SHALL have port reset  input  1  synchronous, active-high reset.
REQ-004 The block SHALL have ports m0_req / m1_req  input  1  master request; held high, with fields stable, until the matching ack.
REQ-005 The block SHALL have ports m0_addr / m1_addr  input  32  byte address.
REQ-006 The block SHALL have ports m0_wdata / m1_wdata  input  32  write data.
REQ-007 The block SHALL have ports m0_we / m1_we  input  1  1 = write, 0 = read.
REQ-008 The block SHALL have ports m0_width / m1_width  input  2  0 = byte, 1 = half, 2 = word.
REQ-009 The block SHALL have ports m0_lock / m1_lock  input  1  retain ownership for the next access.
REQ-010 The block SHALL have ports m0_ack / m1_ack  output  1  one-cycle completion pulse.
REQ-011 The block SHALL have ports m0_err / m1_err  output  1  qualifies ack; 1 = timeout.
REQ-012 The block SHALL have ports m0_rdata / m1_rdata  output  32  read data, valid with ack.
REQ-013 The block SHALL have port mem_req  output  1  access strobe to the memory slave.
REQ-014 The block SHALL have ports mem_addr (32), mem_dout (32), mem_write_en (1), mem_read_en (1) and mem_width (2), all outputs, forwarded from the granted master.
REQ-015 The block SHALL have port mem_din  input  32  slave read data.
REQ-016 The block SHALL have port mem_ack  input  1  slave completion; sampled only while mem_req = 1.

Function
REQ-017 The FSM SHALL have states IDLE, BUSY and RESP, plus an owner register (0 or 1) and a last_owner register.
REQ-018 In IDLE with any req high, the block SHALL latch the owner and the owner's addr/wdata/we/width into registers and enter BUSY on the next edge.
REQ-019 Arbitration SHALL be round-robin: when both requests are high, the master that is not last_owner wins.
REQ-020 Lock override: if lock_hold is set and the held master requests in IDLE, that master SHALL win regardless of round-robin.
REQ-021 In BUSY, mem_req SHALL be 1 and the mem_* outputs SHALL drive the latched fields; mem_read_en = ~we and mem_write_en = we; all other states drive mem_* = 0.
REQ-022 When mem_ack = 1 in BUSY, the block SHALL capture mem_din into rdata_reg, clear err, and enter RESP.
REQ-023 A BUSY cycle counter SHALL clear on entry to BUSY. If it reaches TIMEOUT_CYCLES without mem_ack, the block SHALL enter RESP with err = 1 and rdata = 0.
REQ-024 In RESP (exactly one cycle), the owner's ack and rdata SHALL be driven, err SHALL equal err_reg, the other master's outputs SHALL be 0, and the FSM SHALL return to IDLE.
REQ-025 On RESP exit: last_owner <= owner; lock_hold <= owner's lock sampled in RESP; lock_hold SHALL clear if the held master does not request in the following IDLE.
REQ-026 Minimum latency SHALL be req rise -> mem_req at +1 cycle; mem_ack -> ack at +1 cycle; 3 cycles total for a zero-wait slave.
REQ-027 A request arriving during BUSY or RESP SHALL wait; a request SHALL never be dropped.
REQ-028 mem_ack outside BUSY SHALL be ignored.
REQ-029 A master deasserting req mid-transaction SHALL NOT abort it; ack is still issued.

Reset
REQ-030 Reset SHALL force state = IDLE, owner = 0, last_owner = 1 (so m0 has first priority), lock_hold = 0, counter = 0, and err_reg = rdata_reg = 0.
REQ-031 All outputs SHALL be 0 during and after reset until the next grant.
REQ-032 Reset asserted mid-BUSY SHALL abort the access immediately; no ack SHALL be issued.

Structure
REQ-033 Package mem_arb_pkg SHALL hold the state encoding (IDLE = 0, BUSY = 1, RESP = 2), master indices M0 = 0 and M1 = 1, and width codes.
REQ-034 Round-robin/lock selection SHALL live in the combinational sub-module arb_pick (inputs: reqs, last_owner, lock_hold, lock_owner; output: winner).
REQ-035 The counter width SHALL be clog2(TIMEOUT_CYCLES+1).

Verification
REQ-036 m0 word read at addr 0x100, slave acks in the first BUSY cycle with mem_din 0xDEADBEEF -> m0_ack at cycle 3 with m0_rdata 0xDEADBEEF and err 0.
REQ-037 m0 and m1 request simultaneously from reset -> m0 is served first, then m1; then both again -> m0 first again (m1 was last_owner).
REQ-038 m1 holds m1_lock = 1 across 3 accesses while m0 requests continuously -> three m1 grants back-to-back; m0 is granted after m1_lock drops.
REQ-039 Slave never acks with TIMEOUT_CYCLES = 4 -> mem_req is high for 4 cycles, then m0_ack = 1, m0_err = 1, m0_rdata = 0.
REQ-040 Reset pulsed in the second BUSY cycle of an m1 byte write (0x20 <= 0xAB) -> mem_req = 0 the next cycle, no m1_ack, and the arbiter is IDLE with m0 priority.
